// File: rtl/font_glyph_fetch.sv
// font_glyph_fetch
//   Fetches one glyph row from the font ROM and serialises it as CHAR_W
//   colour pixels, MSB first. Each pixel is the foreground colour for a set
//   bitmap bit and the background colour for a clear bit.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   io_req_*        glyph-row request (code, row, fg, bg) with valid/ready
//   io_rom_addr     registered font ROM address {code,row}
//   io_rom_data     font ROM row bitmap, sampled ROM_LAT cycles after the
//                   address becomes stable
//   io_pix_*        pixel stream (colour, last-of-row) with valid/ready
module font_glyph_fetch #(
  parameter  int CODE_W  = 8,
  parameter  int CHAR_H  = 16,
  parameter  int CHAR_W  = 8,
  parameter  int ROM_LAT = 0,
  parameter  int COLOR_W = 12,
  localparam int ROW_W   = $clog2(CHAR_H),
  localparam int ADDR_W  = CODE_W + ROW_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               io_req_valid,
  output logic               io_req_ready,
  input  logic [CODE_W-1:0]  io_req_code,
  input  logic [ROW_W-1:0]   io_req_row,
  input  logic [COLOR_W-1:0] io_req_fg,
  input  logic [COLOR_W-1:0] io_req_bg,
  output logic [ADDR_W-1:0]  io_rom_addr,
  input  logic [CHAR_W-1:0]  io_rom_data,
  output logic               io_pix_valid,
  input  logic               io_pix_ready,
  output logic [COLOR_W-1:0] io_pix_color,
  output logic               io_pix_last
);

  localparam int CNT_W = $clog2(CHAR_W);
  localparam logic [1:0] WAIT_LAST = 2'(ROM_LAT);
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CHAR_W - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  rom_addr_q;
  logic [COLOR_W-1:0] fg_q;
  logic [COLOR_W-1:0] bg_q;
  logic [COLOR_W-1:0] pix_color_q;
  logic [CHAR_W-1:0]  shift_q;
  logic [CNT_W-1:0]   pix_cnt_q;
  logic [1:0]         wait_cnt_q;
  logic               pix_valid_q;
  logic               pix_last_q;

  logic req_fire;
  logic pix_fire;

  // A new request may be taken while the last pixel of the current row is
  // being consumed, so rows can follow each other without an idle cycle.
  assign io_req_ready = (state_q == S_IDLE) ||
                        ((state_q == S_SHIFT) && pix_last_q && io_pix_ready);
  assign req_fire     = io_req_valid && io_req_ready;
  assign pix_fire     = pix_valid_q && io_pix_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      pix_color_q <= '0;
      shift_q     <= '0;
      pix_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // accept handled below
        end
        S_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            // The first pixel colour is taken straight from the ROM word so
            // that the pixel is valid in the very first SHIFT cycle.
            shift_q     <= io_rom_data;
            pix_color_q <= io_rom_data[CHAR_W-1] ? fg_q : bg_q;
            pix_cnt_q   <= '0;
            pix_last_q  <= 1'b0;
            pix_valid_q <= 1'b1;
            wait_cnt_q  <= '0;
            state_q     <= S_SHIFT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end
        end
        S_SHIFT: begin
          if (pix_fire) begin
            if (pix_last_q) begin
              pix_valid_q <= 1'b0;
              pix_last_q  <= 1'b0;
              state_q     <= S_IDLE;   // overridden by an accept below
            end else begin
              // Next pixel comes from the bit just below the current MSB.
              shift_q     <= shift_q << 1;
              pix_cnt_q   <= pix_cnt_q + CNT_W'(1);
              pix_color_q <= shift_q[CHAR_W-2] ? fg_q : bg_q;
              pix_last_q  <= (pix_cnt_q == CNT_PRE_LAST);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Accept only happens in IDLE or on the last pixel handshake; it
      // snapshots fg/bg so later changes on the request port do not leak
      // into the glyph in flight.
      if (req_fire) begin
        rom_addr_q <= {io_req_code, io_req_row};
        fg_q       <= io_req_fg;
        bg_q       <= io_req_bg;
        wait_cnt_q <= '0;
        state_q    <= S_WAIT;
      end
    end
  end

  assign io_rom_addr  = rom_addr_q;
  assign io_pix_valid = pix_valid_q;
  assign io_pix_color = pix_color_q;
  assign io_pix_last  = pix_last_q;

endmodule

// File: tb/tb_font_glyph_fetch.sv
// Testbench for font_glyph_fetch: unit 0 uses ROM_LAT=0, unit 1 ROM_LAT=2.
// A scoreboard queue per unit receives the expected pixels at request
// accept and is drained as the DUT hands pixels over.
module tb_font_glyph_fetch;

  typedef struct packed {
    logic [11:0] color;
    logic        last;
  } pix_t;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;

  logic        req_valid [2];
  logic        req_ready [2];
  logic [7:0]  req_code  [2];
  logic [3:0]  req_row   [2];
  logic [11:0] req_fg    [2];
  logic [11:0] req_bg    [2];
  logic [11:0] rom_addr  [2];
  logic [7:0]  rom_data  [2];
  logic        pix_valid [2];
  logic        pix_ready [2];
  logic [11:0] pix_color [2];
  logic        pix_last  [2];

  logic [7:0]  rom_mem [4096];

  pix_t        exp_q [2][$];
  int          first_cyc [2];
  int          acc_cyc   [2];
  int          last_cyc  [2];
  logic [11:0] addr_exp  [2];
  logic [11:0] addr_pend [2];
  logic        addr_pend_v [2];
  logic        hold_v    [2];
  logic [11:0] hold_col  [2];
  logic        hold_last [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unit
      logic [11:0] a1_q;
      logic [11:0] a2_q;

      font_glyph_fetch #(.ROM_LAT(gi * 2)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .io_req_valid (req_valid[gi]),
        .io_req_ready (req_ready[gi]),
        .io_req_code  (req_code[gi]),
        .io_req_row   (req_row[gi]),
        .io_req_fg    (req_fg[gi]),
        .io_req_bg    (req_bg[gi]),
        .io_rom_addr  (rom_addr[gi]),
        .io_rom_data  (rom_data[gi]),
        .io_pix_valid (pix_valid[gi]),
        .io_pix_ready (pix_ready[gi]),
        .io_pix_color (pix_color[gi]),
        .io_pix_last  (pix_last[gi])
      );

      // ROM model: data follows the address after ROM_LAT cycles; before
      // that it still shows the word of the previous address.
      always @(posedge clk) begin
        a1_q <= rom_addr[gi];
        a2_q <= a1_q;
      end
      assign rom_data[gi] = (gi == 0) ? rom_mem[rom_addr[gi]] : rom_mem[a2_q];
    end
  endgenerate

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        exp_q[u].delete();
        addr_exp[u]    = '0;
        addr_pend_v[u] = 1'b0;
        hold_v[u]      = 1'b0;
      end else begin
        logic ev;
        logic er;
        pix_t p;
        logic [7:0] bm;
        if (addr_pend_v[u]) begin
          addr_exp[u]    = addr_pend[u];
          addr_pend_v[u] = 1'b0;
        end
        check_eq($sformatf("u%0d_rom_addr", u), rom_addr[u], addr_exp[u]);
        ev = (exp_q[u].size() > 0) && (cyc >= first_cyc[u]);
        er = (exp_q[u].size() == 0) || ((exp_q[u].size() == 1) && pix_ready[u]);
        check_eq($sformatf("u%0d_pix_valid", u), pix_valid[u], ev);
        check_eq($sformatf("u%0d_req_ready", u), req_ready[u], er);
        if (hold_v[u]) begin
          check_eq($sformatf("u%0d_hold_color", u), pix_color[u], hold_col[u]);
          check_eq($sformatf("u%0d_hold_last", u), pix_last[u], hold_last[u]);
        end
        hold_v[u]    = pix_valid[u] && !pix_ready[u];
        hold_col[u]  = pix_color[u];
        hold_last[u] = pix_last[u];
        if (ev && pix_ready[u]) begin
          p = exp_q[u].pop_front();
          $display("u%0d pix cycle=%0d color=%03h last=%0d", u, cyc, pix_color[u], pix_last[u]);
          check_eq($sformatf("u%0d_pix_color", u), pix_color[u], p.color);
          check_eq($sformatf("u%0d_pix_last", u), pix_last[u], p.last);
          if (p.last) last_cyc[u] = cyc;
        end
        if (req_valid[u] && req_ready[u]) begin
          bm = rom_mem[{req_code[u], req_row[u]}];
          $display("u%0d req cycle=%0d code=%02h row=%0h bitmap=%02h", u, cyc,
                   req_code[u], req_row[u], bm);
          for (int i = 0; i < 8; i++) begin
            p.color = bm[7-i] ? req_fg[u] : req_bg[u];
            p.last  = (i == 7);
            exp_q[u].push_back(p);
          end
          first_cyc[u]   = cyc + 2 * u + 2;
          acc_cyc[u]     = cyc;
          addr_pend[u]   = {req_code[u], req_row[u]};
          addr_pend_v[u] = 1'b1;
        end
      end
    end
  end

  // Called and returning at #1 after a rising edge.
  task automatic send_req(input int u, input logic [7:0] code, input logic [3:0] row,
                          input logic [11:0] fg, input logic [11:0] bg, input logic [7:0] bm);
    int n;
    n = 0;
    rom_mem[{code, row}] = bm;
    req_code[u]  = code;
    req_row[u]   = row;
    req_fg[u]    = fg;
    req_bg[u]    = bg;
    req_valid[u] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[u] && n < 300);
    check_eq($sformatf("u%0d_req_accept_timeout", u), (n < 300), 1);
    @(posedge clk);
    #1;
    req_valid[u] = 1'b0;
    // Colours change after accept; the glyph in flight must not notice.
    req_fg[u] = 12'hBAD;
    req_bg[u] = 12'hDAD;
  endtask

  task automatic wait_idle(input int u);
    int n;
    n = 0;
    while (exp_q[u].size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("u%0d_drain_timeout", u), (n < 300), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'h00;
    rom_mem[0] = 8'h5A;   // stale word seen before the ROM latency elapses
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0;
      req_code[u]  = '0;
      req_row[u]   = '0;
      req_fg[u]    = '0;
      req_bg[u]    = '0;
      pix_ready[u] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check_eq($sformatf("u%0d_rst_valid", u), pix_valid[u], 0);
      check_eq($sformatf("u%0d_rst_ready", u), req_ready[u], 1);
      check_eq($sformatf("u%0d_rst_addr", u), rom_addr[u], 0);
      check_eq($sformatf("u%0d_rst_color", u), pix_color[u], 0);
      check_eq($sformatf("u%0d_rst_last", u), pix_last[u], 0);
    end
    @(posedge clk);
    #1;

    // Basic row on both latencies
    for (int u = 0; u < 2; u++) begin
      send_req(u, 8'h41, 4'h3, 12'hFFF, 12'h000, 8'b1010_0001);
      wait_idle(u);
    end

    // Backpressure on pixel 2 for three cycles
    for (int u = 0; u < 2; u++) begin
      send_req(u, 8'h43, 4'h3, 12'h123, 12'h456, 8'b0110_1001);
      repeat (2 * u + 3) @(posedge clk);
      #1;
      pix_ready[u] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      pix_ready[u] = 1'b1;
      wait_idle(u);
    end

    // Back-to-back rows
    for (int u = 0; u < 2; u++) begin
      send_req(u, 8'h41, 4'h3, 12'hFFF, 12'h000, 8'b1010_0001);
      send_req(u, 8'h42, 4'h3, 12'hFFF, 12'h000, 8'b0011_1100);
      check_eq($sformatf("u%0d_b2b_accept_cycle", u), acc_cyc[u], last_cyc[u]);
      wait_idle(u);
    end

    // Reset in SHIFT after pixel 3, then a fresh row
    send_req(0, 8'h44, 4'h5, 12'hAAA, 12'h555, 8'b1100_0011);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("u0_midrst_valid", pix_valid[0], 0);
    check_eq("u0_midrst_ready", req_ready[0], 1);
    check_eq("u0_midrst_addr", rom_addr[0], 0);
    @(posedge clk);
    #1;
    send_req(0, 8'h45, 4'h6, 12'h321, 12'h654, 8'b1001_0110);
    wait_idle(0);

    // All-ones and all-zeros bitmaps
    for (int u = 0; u < 2; u++) begin
      send_req(u, 8'h46, 4'h0, 12'h0F0, 12'hF00, 8'hFF);
      wait_idle(u);
      send_req(u, 8'h47, 4'hF, 12'h0F0, 12'hF00, 8'h00);
      wait_idle(u);
    end

    for (int u = 0; u < 2; u++)
      check_eq($sformatf("u%0d_queue_empty", u), exp_q[u].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
